// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-arbiter state encoding and default sizing.
package uart_pkg;

  localparam int unsigned UART_DATA_W      = 8;
  localparam int unsigned TX_ARB_N_REQ     = 4;
  localparam int unsigned TX_ARB_MAX_BEATS = 16;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT     = 2'd1,
    ARB_CFG_DRAIN = 2'd2,
    ARB_CFG_REQ   = 2'd3
  } tx_arbiter_fsm_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// searching upward and wrapping past N-1.
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic             found_o
);

  always_comb begin
    logic        hit;
    int unsigned idx;
    hit     = 1'b0;
    idx     = 0;
    grant_o = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!hit && req_i[PTR_W'(idx)]) begin
        hit                    = 1'b1;
        grant_o[PTR_W'(idx)]   = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/tx_arbiter.sv
// Packet-locked round-robin arbiter for the UART TX FIFO write port, with a
// drain-then-handshake sequencer for master configuration requests.
module tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ     = TX_ARB_N_REQ,
  parameter int unsigned MAX_BEATS = TX_ARB_MAX_BEATS
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [N_REQ-1:0]                      req_valid_i,
  input  logic [N_REQ-1:0][UART_DATA_W-1:0]     req_data_i,
  input  logic [N_REQ-1:0]                      req_last_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic                                  cfg_req_i,
  input  logic                                  tx_fifo_full_i,
  input  logic                                  tx_fifo_empty_i,
  input  logic                                  tx_idle_i,
  input  logic                                  req_done_i,
  output logic [UART_DATA_W-1:0]                tx_data_o,
  output logic                                  tx_fifo_write_o,
  output logic                                  config_req_mst_o,
  output logic [N_REQ-1:0]                      grant_o,
  output logic                                  cfg_busy_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);

  tx_arbiter_fsm_e   state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              pending_q, pending_d;
  logic [N_REQ-1:0]  grant_q, grant_d;

  logic [N_REQ-1:0]       pick_grant;
  logic                   pick_found;
  logic [PTR_W-1:0]       owner_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic [UART_DATA_W-1:0] sel_data;
  logic                   beat_accept;
  logic [CNT_W-1:0]       beat_inc;
  logic                   at_limit;
  logic [PTR_W-1:0]       owner_next;

  rr_priority_picker #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .found_o (pick_found)
  );

  // Owner mux; everything reads zero when no grant is held.
  always_comb begin
    owner_idx = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = PTR_W'(i);
        sel_valid = req_valid_i[i];
        sel_last  = req_last_i[i];
        sel_data  = req_data_i[i];
      end
    end
  end

  assign beat_accept = sel_valid & ~tx_fifo_full_i;
  assign beat_inc    = beat_cnt_q + CNT_W'(1);
  assign at_limit    = (beat_inc == CNT_W'(MAX_BEATS));
  assign owner_next  = (owner_idx == PTR_W'(N_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    beat_cnt_d       = beat_cnt_q;
    grant_d          = grant_q;
    pending_d        = pending_q | cfg_req_i;
    req_ready_o      = '0;
    tx_fifo_write_o  = 1'b0;
    tx_data_o        = '0;
    config_req_mst_o = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // A pending configuration outranks any waiting requester.
        if (pending_q | cfg_req_i) begin
          state_d = ARB_CFG_DRAIN;
        end else if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick_grant;
        end
      end

      ARB_GRANT: begin
        req_ready_o     = grant_q & {N_REQ{~tx_fifo_full_i}};
        tx_fifo_write_o = beat_accept;
        tx_data_o       = sel_data;
        if (beat_accept) begin
          beat_cnt_d = beat_inc;
          if (sel_last | at_limit) begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = owner_next;
          end
        end
      end

      ARB_CFG_DRAIN: begin
        // Entry to the handshake consumes the pending flag; a fresh request re-arms it.
        if (tx_fifo_empty_i & tx_idle_i) begin
          state_d   = ARB_CFG_REQ;
          pending_d = cfg_req_i;
        end
      end

      ARB_CFG_REQ: begin
        config_req_mst_o = 1'b1;
        if (req_done_i) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      pending_q  <= 1'b0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
    end
  end

  assign grant_o    = grant_q;
  assign cfg_busy_o = (state_q == ARB_CFG_DRAIN) | (state_q == ARB_CFG_REQ);

endmodule
